divider_16bit_seq: RTL

//   Iterative restoring unsigned divider: the inverse datapath of the Vedic

---
 rtl/divider_16bit_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/divider_16bit_seq.sv
// divider_16bit_seq: iterative restoring unsigned divider, one quotient bit per clock.
// Valid/ready handshake on the operand side and on the result side.
// Optional feature macro: DIV_ZERO_FLAG_EN adds the div_zero output flag.
// Divide-by-zero returns quotient = all ones and remainder = dividend, with or without the flag.
module divider_16bit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,output logic            div_zero
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_div_by_zero;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_trial_neg;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // Handshake and one restoring step. The partial remainder always stays below
  // the divisor, so a WIDTH+1 bit trial difference carries a valid sign bit.
  assign w_accept      = in_valid && (r_state == S_IDLE);
  assign w_div_by_zero = (divisor == {WIDTH{1'b0}});
  assign w_rem_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial       = w_rem_shift - {1'b0, r_divisor};
  assign w_trial_neg   = w_trial[WIDTH];
  assign w_rem_next    = w_trial_neg ? w_rem_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next    = {r_quo[WIDTH-2:0], ~w_trial_neg};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: IDLE -> CALC (or straight to DONE on a zero divisor) -> DONE -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_div_by_zero) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_CALC;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_CALC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, publish results only on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem       <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_divisor   <= {WIDTH{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_quotient  <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_divisor <= divisor;
            if (w_div_by_zero) begin
              r_quotient  <= {WIDTH{1'b1}};
              r_remainder <= dividend;
              r_out_valid <= 1'b1;
            end else begin
              r_rem <= {WIDTH{1'b0}};
              r_quo <= dividend;
              r_cnt <= CW'(WIDTH - 1);
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == {CW{1'b0}}) begin
            r_quotient  <= w_quo_next;
            r_remainder <= w_rem_next;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic r_div_zero;

  assign div_zero = r_div_zero;

  // Divide-by-zero flag: raised with the result, held through DONE, low again in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_div_zero <= w_div_by_zero;
    end else if ((r_state == S_DONE) && out_ready) begin
      r_div_zero <= 1'b0;
    end
  end
`endif

endmodule
